// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with load clamp, wrap/saturate and
// carry/borrow pulses; digits ripple-enable through a generate chain.
module bcd_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] bcd,
  output logic                co,
  output logic                bo,
  output logic                zero,
  output logic                err
);

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_co;
  logic                r_bo;
  logic                r_err;

  logic [DIGITS:0]     w_all9;
  logic [DIGITS:0]     w_all0;
  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_ld;
  logic [DIGITS-1:0]   w_bad;
  logic                w_max;
  logic                w_min;

  assign w_all9[0] = 1'b1;
  assign w_all0[0] = 1'b1;

  // w_all9[k]/w_all0[k] form the ripple enable for digit k
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [3:0] w_d;
    logic [3:0] w_in;
    assign w_d  = r_bcd[4*g +: 4];
    assign w_in = din[4*g +: 4];

    assign w_all9[g+1] = w_all9[g] & (w_d == 4'd9);
    assign w_all0[g+1] = w_all0[g] & (w_d == 4'd0);

    assign w_inc[4*g +: 4] = !w_all9[g] ? w_d :
                             (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
    assign w_dec[4*g +: 4] = !w_all0[g] ? w_d :
                             (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;

    assign w_bad[g]       = (w_in > 4'd9);
    assign w_ld[4*g +: 4] = w_bad[g] ? 4'd9 : w_in;
  end

  assign w_max = w_all9[DIGITS];
  assign w_min = w_all0[DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd <= '0;
      r_co  <= 1'b0;
      r_bo  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_co  <= 1'b0;
      r_bo  <= 1'b0;
      r_err <= 1'b0;
      if (load) begin
        r_bcd <= w_ld;
        r_err <= |w_bad;
      end else if (en) begin
        if (up) begin
          r_co <= w_max;
          if (!w_max || WRAP) r_bcd <= w_inc;
        end else begin
          r_bo <= w_min;
          if (!w_min || WRAP) r_bcd <= w_dec;
        end
      end
    end
  end

  assign bcd  = r_bcd;
  assign co   = r_co;
  assign bo   = r_bo;
  assign err  = r_err;
  assign zero = (r_bcd == '0);

endmodule

// File: tb/tb_bcd_counter.sv
// Directed and reference-model checks for bcd_counter, run on a wrapping
// and a saturating instance side by side.
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] w_bcd, s_bcd;
  logic       w_co, w_bo, w_zero, w_err;
  logic       s_co, s_bo, s_zero, s_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(2), .WRAP(1'b1)) u_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .bcd(w_bcd), .co(w_co), .bo(w_bo), .zero(w_zero), .err(w_err)
  );

  bcd_counter #(.DIGITS(2), .WRAP(1'b0)) u_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .bcd(s_bcd), .co(s_co), .bo(s_bo), .zero(s_zero), .err(s_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit dig_ok(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  function automatic logic [7:0] to_bcd(input int m);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(m / 10);
    lo = 4'(m % 10);
    return {hi, lo};
  endfunction

  // each digit would feed a one-hot decimal decoder; it must stay in range
  always @(negedge clk) begin
    chk("range_w", int'(dig_ok(w_bcd)), 1);
    chk("range_s", int'(dig_ok(s_bcd)), 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    din  = v;
    tick();
    load = 1'b0;
  endtask

  int mw, ms, v, hi, lo, ld_err;
  logic r_ld, r_en, r_up;
  logic [7:0] r_din;

  initial begin
    #2;
    chk("rst_bcd", w_bcd, 8'h00);
    chk("rst_flags", {w_co, w_bo, w_err, w_zero}, 4'b0001);
    @(negedge clk);
    rst = 1'b0;

    // abort mid-count
    do_load(8'h36);
    en = 1'b1; up = 1'b1;
    tick();
    chk("pre_rst", w_bcd, 8'h37);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_w", w_bcd, 8'h00);
    chk("async_rst_s", s_bcd, 8'h00);
    chk("async_flags", {w_co, w_bo, w_err}, 3'b000);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_load(8'h08);
    chk("ld08", w_bcd, 8'h08);
    en = 1'b1; up = 1'b1;
    tick(); chk("up09", w_bcd, 8'h09);
    tick(); chk("up10", w_bcd, 8'h10);
    tick(); chk("up11", w_bcd, 8'h11);
    chk("up_co0", w_co, 0);

    en = 1'b0;
    do_load(8'h98);
    en = 1'b1;
    tick(); chk("up99", w_bcd, 8'h99);
    chk("up99_co", w_co, 0);
    tick();
    chk("wrap00", w_bcd, 8'h00);
    chk("wrap_co", w_co, 1);
    chk("wrap_zero", w_zero, 1);
    chk("sat99", s_bcd, 8'h99);
    chk("sat_co", s_co, 1);
    tick();
    chk("wrap01", w_bcd, 8'h01);
    chk("wrap_co_clr", w_co, 0);
    chk("sat_co_again", {s_co, s_bcd}, 9'h199);
    en = 1'b0;
    tick();
    chk("hold_co", {s_co, s_bcd}, 9'h099);

    do_load(8'h01);
    en = 1'b1; up = 1'b0;
    tick();
    chk("dn00", w_bcd, 8'h00);
    chk("dn00_bo", w_bo, 0);
    chk("dn00_zero", s_zero, 1);
    tick();
    chk("dnwrap", {w_bo, w_bcd}, 9'h199);
    chk("dnsat", {s_bo, s_bcd}, 9'h100);
    tick();
    chk("dn98", {w_bo, w_bcd}, 9'h098);
    chk("dnsat2", {s_bo, s_bcd}, 9'h100);
    chk("dnsat_zero", s_zero, 1);

    en = 1'b0;
    do_load(8'hC5);
    chk("clamp", w_bcd, 8'h95);
    chk("clamp_err", w_err, 1);
    tick();
    chk("err_clr", {w_err, w_bcd}, 9'h095);
    load = 1'b1; en = 1'b1; up = 1'b1; din = 8'h12;
    tick();
    chk("ld_wins", w_bcd, 8'h12);
    chk("ld_flags", {w_co, w_bo, w_err}, 3'b000);
    load = 1'b0;
    din = 8'hAF;
    load = 1'b1;
    tick();
    chk("clamp2", {w_err, w_bcd}, 9'h199);
    load = 1'b0; en = 1'b0;
    tick();

    // integer reference model, mod 100 (wrap) and clamped (saturate)
    mw = 99; ms = 99;
    for (int i = 0; i < 2000; i++) begin
      r_ld  = ($urandom_range(0, 9) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      r_up  = $urandom_range(0, 1) == 1;
      r_din = 8'($urandom_range(0, 255));
      load = r_ld; en = r_en; up = r_up; din = r_din;
      tick();
      hi = int'(r_din[7:4]); lo = int'(r_din[3:0]);
      ld_err = (hi > 9 || lo > 9) ? 1 : 0;
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      if (r_ld) begin
        mw = hi * 10 + lo; ms = mw;
        chk("rnd_err", w_err, ld_err);
        chk("rnd_cobo", {w_co, w_bo, s_co, s_bo}, 0);
      end else if (r_en && r_up) begin
        chk("rnd_co_w", w_co, int'(mw == 99));
        chk("rnd_co_s", s_co, int'(ms == 99));
        mw = (mw + 1) % 100;
        if (ms < 99) ms++;
      end else if (r_en) begin
        chk("rnd_bo_w", w_bo, int'(mw == 0));
        chk("rnd_bo_s", s_bo, int'(ms == 0));
        mw = (mw + 99) % 100;
        if (ms > 0) ms--;
      end else begin
        chk("rnd_idle", {w_co, w_bo, w_err}, 0);
      end
      chk("rnd_bcd_w", w_bcd, to_bcd(mw));
      chk("rnd_bcd_s", s_bcd, to_bcd(ms));
      chk("rnd_zero", w_zero, int'(mw == 0));
    end

    load = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
